// File: rtl/axi4_wr_slave_mem.sv
// AXI4 write-channel responder backed by an on-chip word memory.
// One burst in flight; byte strobes honoured; debug read port and beat counter.
module axi4_wr_slave_mem #(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_WDATA_WIDTH   = 32,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned MEM_DEPTH_LOG2     = 10,
  parameter logic [AXI4_ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                          iclk,
  input  logic                          rst_n,
  input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
  input  logic [7:0]                    aw_len_i,
  input  logic [2:0]                    aw_size_i,
  input  logic [1:0]                    aw_burst_i,
  input  logic [AXI4_USER_WIDTH-1:0]    aw_user_i,
  input  logic                          aw_valid_i,
  output logic                          aw_ready_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI4_WDATA_WIDTH/8-1:0] w_strb_i,
  input  logic                          w_last_i,
  input  logic [AXI4_USER_WIDTH-1:0]    w_user_i,
  input  logic                          w_valid_i,
  output logic                          w_ready_o,
  output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
  output logic [1:0]                    b_resp_o,
  output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
  output logic                          b_valid_o,
  input  logic                          b_ready_i,
  input  logic [MEM_DEPTH_LOG2-1:0]     rd_addr_i,
  output logic [AXI4_WDATA_WIDTH-1:0]   rd_data_o,
  output logic [31:0]                   wr_count_o
);
  localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned NSTRB = AXI4_WDATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                          state_q, state_d;
  logic                            aw_ready_q, w_ready_q, b_valid_q;
  logic [AXI4_ID_WIDTH-1:0]        id_q;
  logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
  logic [7:0]                      len_q, cnt_q;
  logic                            fixed_q, aw_err_q, err_q;
  logic [AXI4_USER_WIDTH-1:0]      b_user_q;
  logic [31:0]                     wr_count_q;
  logic [AXI4_WDATA_WIDTH-1:0]     rd_data_q;
  logic [AXI4_WDATA_WIDTH-1:0]     mem [DEPTH];

  logic                            aw_hs, w_hs, b_hs, beat_last, in_range, do_write;
  logic [AXI4_ADDRESS_WIDTH-1:0]   off;
  logic [MEM_DEPTH_LOG2-1:0]       word_idx;
  logic                            unused_ok;

  assign aw_hs     = aw_valid_i & aw_ready_q;
  assign w_hs      = w_valid_i & w_ready_q;
  assign b_hs      = b_valid_q & b_ready_i;
  assign beat_last = (cnt_q == len_q);
  assign off       = addr_q - BASE_ADDR;
  assign in_range  = (addr_q >= BASE_ADDR) && ((off >> (MEM_DEPTH_LOG2 + 2)) == '0);
  assign word_idx  = off[MEM_DEPTH_LOG2+1:2];
  // An AW-level error discards every beat; range errors drop only the offending beat.
  assign do_write  = w_hs & ~aw_err_q & in_range;
  assign unused_ok = ^{aw_user_i, off[1:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (aw_hs) state_d = DATA;
      DATA: if (w_hs && beat_last) state_d = RESP;
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      fixed_q    <= 1'b0;
      aw_err_q   <= 1'b0;
      err_q      <= 1'b0;
      b_user_q   <= '0;
      wr_count_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      aw_ready_q <= (state_d == IDLE);
      w_ready_q  <= (state_d == DATA);
      b_valid_q  <= (state_d == RESP);
      rd_data_q  <= mem[rd_addr_i];
      if (aw_hs) begin
        id_q     <= aw_id_i;
        addr_q   <= aw_addr_i;
        len_q    <= aw_len_i;
        cnt_q    <= '0;
        fixed_q  <= (aw_burst_i == 2'd0);
        aw_err_q <= (aw_size_i != 3'd2) || (aw_burst_i == 2'd2);
        err_q    <= (aw_size_i != 3'd2) || (aw_burst_i == 2'd2);
      end
      if (w_hs) begin
        cnt_q <= cnt_q + 8'd1;
        if (!fixed_q) addr_q <= addr_q + AXI4_ADDRESS_WIDTH'(4);
        if (!in_range || (beat_last != w_last_i)) err_q <= 1'b1;
        if (beat_last) b_user_q <= w_user_i;
        if (do_write) wr_count_q <= wr_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge iclk) begin
    if (do_write) begin
      for (int unsigned i = 0; i < NSTRB; i++) begin
        if (w_strb_i[i]) mem[word_idx][8*i +: 8] <= w_data_i[8*i +: 8];
      end
    end
  end

  assign aw_ready_o = aw_ready_q;
  assign w_ready_o  = w_ready_q;
  assign b_valid_o  = b_valid_q;
  assign b_id_o     = id_q;
  assign b_resp_o   = {err_q, 1'b0};
  assign b_user_o   = b_user_q;
  assign rd_data_o  = rd_data_q;
  assign wr_count_o = wr_count_q;
endmodule

// File: tb/tb_axi4_wr_slave_mem.sv
// Self-checking bench for axi4_wr_slave_mem: directed table, hand sequences and
// randomized bursts scored against a behavioural word-array model.
module tb_axi4_wr_slave_mem;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        iclk = 1'b0;
  logic        rst_n;
  logic [15:0] aw_id_i;
  logic [31:0] aw_addr_i;
  logic [7:0]  aw_len_i;
  logic [2:0]  aw_size_i;
  logic [1:0]  aw_burst_i;
  logic [9:0]  aw_user_i;
  logic        aw_valid_i, aw_ready_o;
  logic [31:0] w_data_i;
  logic [3:0]  w_strb_i;
  logic        w_last_i;
  logic [9:0]  w_user_i;
  logic        w_valid_i, w_ready_o;
  logic [15:0] b_id_o;
  logic [1:0]  b_resp_o;
  logic [9:0]  b_user_o;
  logic        b_valid_o, b_ready_i;
  logic [9:0]  rd_addr_i;
  logic [31:0] rd_data_o, wr_count_o;

  axi4_wr_slave_mem #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_WDATA_WIDTH(32), .AXI4_ID_WIDTH(16),
    .AXI4_USER_WIDTH(10), .MEM_DEPTH_LOG2(10), .BASE_ADDR(BASE)
  ) dut (
    .iclk(iclk), .rst_n(rst_n),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i), .aw_user_i(aw_user_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_user_i(w_user_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .wr_count_o(wr_count_o)
  );

  always #5 iclk = ~iclk;

  int checks = 0, failures = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] mdl_cnt = '0;
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];
  logic [9:0]  wu [256];

  typedef struct {
    logic [15:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; int bad_last; int exp_resp;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
    mdl_cnt = mdl_cnt + 32'd1;
  endtask

  task automatic fill_beats(input logic [7:0] len, input int bad_last, input bit rand_strb);
    for (int b = 0; b <= int'(len); b++) begin
      wd[b] = $urandom; ws[b] = rand_strb ? 4'($urandom) : 4'hF;
      wl[b] = (b == int'(len)); wu[b] = 10'($urandom);
    end
    if (bad_last == 1) wl[0] = 1'b1;
    if (bad_last == 2) wl[len] = 1'b0;
  endtask

  task automatic aw_send(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
    aw_user_i = 10'($urandom); aw_valid_i = 1'b1;
    @(negedge iclk);
    while (!aw_ready_o && n < 100) begin @(negedge iclk); n++; end
    if (!aw_ready_o) begin chk("aw_timeout", 0, 1); aw_valid_i = 1'b0; return; end
    @(posedge iclk); #1 aw_valid_i = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l,
                        input logic [9:0] u, input int gap);
    int n = 0;
    if (gap > 0) begin repeat (gap) @(posedge iclk); #1; end
    w_data_i = d; w_strb_i = s; w_last_i = l; w_user_i = u; w_valid_i = 1'b1;
    @(negedge iclk);
    while (!w_ready_o && n < 100) begin @(negedge iclk); n++; end
    if (!w_ready_o) begin chk("w_timeout", 0, 1); w_valid_i = 1'b0; return; end
    @(posedge iclk); #1 w_valid_i = 1'b0;
  endtask

  task automatic b_recv(input string nm, input logic [15:0] id, input logic [1:0] resp,
                        input logic [9:0] user, input int delay);
    int n = 0;
    bit stable = 1'b1;
    b_ready_i = 1'b0;
    @(negedge iclk);
    while (!b_valid_o && n < 100) begin @(negedge iclk); n++; end
    if (!b_valid_o) begin chk({nm, "_b_timeout"}, 0, 1); return; end
    chk({nm, "_bid"}, b_id_o, id);
    chk({nm, "_bresp"}, b_resp_o, resp);
    chk({nm, "_buser"}, b_user_o, user);
    repeat (delay) begin
      @(negedge iclk);
      if (b_valid_o !== 1'b1 || b_id_o !== id || b_resp_o !== resp ||
          b_user_o !== user || aw_ready_o !== 1'b0) stable = 1'b0;
    end
    if (delay > 0) chk({nm, "_b_stable"}, 64'(stable), 1);
    b_ready_i = 1'b1;
    @(posedge iclk); #1 b_ready_i = 1'b0;
    chk({nm, "_b_done"}, {b_valid_o, aw_ready_o}, 2'b01);
  endtask

  task automatic run_burst(input string nm, input logic [15:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input int gap, input int bdelay, input int exp_resp);
    logic err, discard;
    logic [31:0] a;
    int r;
    discard = (size != 3'd2) || (burst == 2'd2);
    err = discard;
    for (int b = 0; b <= int'(len); b++) begin
      a = (burst == 2'd0) ? addr : addr + 32'(4 * b);
      if (a < BASE || (a - BASE) >= 32'(4 * DEPTH)) err = 1'b1;
      else if (!discard) model_write((a - BASE) >> 2, wd[b], ws[b]);
      if (wl[b] != (b == int'(len))) err = 1'b1;
    end
    r = (exp_resp < 0) ? (err ? 2 : 0) : exp_resp;
    aw_send(id, addr, len, size, burst);
    chk({nm, "_aw_phase"}, {aw_ready_o, w_ready_o}, 2'b01);
    for (int b = 0; b <= int'(len); b++)
      w_send(wd[b], ws[b], wl[b], wu[b], (gap > 0) ? int'($urandom_range(gap, 0)) : 0);
    chk({nm, "_w_done"}, {w_ready_o, b_valid_o}, 2'b01);
    b_recv(nm, id, 2'(r), wu[len], bdelay);
    chk({nm, "_count"}, wr_count_o, mdl_cnt);
  endtask

  task automatic rd_check(input string nm, input int unsigned idx);
    @(negedge iclk);
    rd_addr_i = 10'(idx);
    @(posedge iclk); #1;
    chk(nm, rd_data_o, mdl[idx]);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ready"}, {aw_ready_o, w_ready_o, b_valid_o}, 3'b000);
    chk({nm, "_bfields"}, {b_resp_o, b_id_o, b_user_o}, '0);
    chk({nm, "_count"}, wr_count_o, 0);
    chk({nm, "_rdata"}, rd_data_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; aw_valid_i = 1'b0; w_valid_i = 1'b0; b_ready_i = 1'b0;
    aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0; aw_user_i = '0;
    w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_user_i = '0; rd_addr_i = '0;

    vecs[0] = '{16'h0001, BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'd1, 0, 2};
    vecs[1] = '{16'h0002, BASE + 32'h20, 8'd0, 3'd1, 2'd1, 0, 2};
    vecs[2] = '{16'h0003, BASE + 32'h40, 8'd3, 3'd2, 2'd2, 0, 2};
    vecs[3] = '{16'h0004, BASE + 32'h60, 8'd1, 3'd2, 2'd1, 1, 2};
    vecs[4] = '{16'h0005, BASE - 32'd4,  8'd0, 3'd2, 2'd1, 0, 2};
    vecs[5] = '{16'h0006, BASE + 32'(4 * (DEPTH - 2)), 8'd3, 3'd2, 2'd1, 0, 2};
    vecs[6] = '{16'h0007, BASE + 32'h80, 8'd2, 3'd2, 2'd0, 0, 0};
    vecs[7] = '{16'h0008, BASE + 32'h100, 8'd7, 3'd2, 2'd1, 0, 0};
    vecs[8] = '{16'h0009, BASE + 32'h200, 8'd1, 3'd2, 2'd1, 2, 2};

    repeat (3) @(posedge iclk);
    #1 chk_reset_outputs("reset");
    @(negedge iclk) rst_n = 1'b1;
    #1 chk("aw_ready_pre_edge", aw_ready_o, 0);
    @(posedge iclk); #1 chk("aw_ready_post_reset", aw_ready_o, 1);

    // Single beat, then strobe merge into the same word.
    fill_beats(8'd0, 0, 1'b0);
    wd[0] = 32'hDEAD_BEEF;
    run_burst("single", 16'h005A, BASE + 32'h10, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    chk("single_count_abs", wr_count_o, 1);
    rd_check("single_rd", 4);
    chk("single_rd_abs", rd_data_o, 32'hDEAD_BEEF);
    fill_beats(8'd0, 0, 1'b0);
    wd[0] = 32'h1122_3344; ws[0] = 4'b0101;
    run_burst("strobe", 16'h0011, BASE + 32'h10, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    rd_check("strobe_rd", 4);
    chk("strobe_rd_abs", rd_data_o, 32'hDE22_BE44);

    // Preload the whole memory so every word is known to the model.
    for (int k = 0; k < 4; k++) begin
      fill_beats(8'd255, 0, 1'b0);
      run_burst("preload", 16'(k), BASE + 32'(k * 1024), 8'd255, 3'd2, 2'd1, 0, 0, 0);
    end

    fill_beats(8'd3, 0, 1'b0);
    for (int b = 0; b < 4; b++) wd[b] = 32'(b + 1);
    run_burst("incr4", 16'h0100, BASE, 8'd3, 3'd2, 2'd1, 2, 0, 0);
    for (int i = 0; i < 4; i++) rd_check("incr4_rd", i);
    chk("incr4_word3_abs", rd_data_o, 32'd4);

    fill_beats(8'd2, 0, 1'b0);
    wd[0] = 32'hA; wd[1] = 32'hB; wd[2] = 32'hC;
    run_burst("fixed3", 16'h0200, BASE + 32'h14, 8'd2, 3'd2, 2'd0, 1, 0, 0);
    rd_check("fixed3_rd", 5);
    chk("fixed3_rd_abs", rd_data_o, 32'hC);
    rd_check("fixed3_neighbour", 6);

    for (int v = 0; v < 9; v++) begin
      fill_beats(vecs[v].len, vecs[v].bad_last, 1'b0);
      run_burst($sformatf("vec%0d", v), vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].size,
                vecs[v].burst, 1, (v == 3) ? 5 : 0, vecs[v].exp_resp);
      rd_check($sformatf("vec%0d_mem", v), ((vecs[v].addr - BASE) >> 2) & (DEPTH - 1));
    end
    rd_check("wrap_tail_mem", 1023);

    for (int t = 0; t < 20; t++) begin
      logic [7:0] len;
      logic [1:0] burst;
      len = 8'($urandom_range(7, 0));
      burst = 2'($urandom_range(1, 0));
      fill_beats(len, ($urandom_range(7, 0) == 0) ? 2 : 0, 1'b1);
      run_burst($sformatf("rnd%0d", t), 16'($urandom), BASE + 32'(4 * $urandom_range(DEPTH + 4, 0)),
                len, ($urandom_range(9, 0) == 0) ? 3'd1 : 3'd2, burst, 2,
                int'($urandom_range(3, 0)), -1);
    end
    for (int t = 0; t < 40; t++) rd_check("rnd_rd", $urandom_range(DEPTH - 1, 0));

    // B back-pressure, then reset mid-burst after one beat lands.
    fill_beats(8'd0, 0, 1'b0);
    run_burst("bp", 16'h0BAD, BASE + 32'h300, 8'd0, 3'd2, 2'd1, 0, 5, 0);
    aw_send(16'h0123, BASE + 32'h304, 8'd3, 3'd2, 2'd1);
    w_send(32'hCAFE_F00D, 4'hF, 1'b0, 10'h3, 0);
    model_write(32'h304 >> 2, 32'hCAFE_F00D, 4'hF);
    @(negedge iclk) rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    mdl_cnt = '0;
    repeat (2) @(negedge iclk);
    rst_n = 1'b1;
    @(posedge iclk); #1;
    fill_beats(8'd0, 0, 1'b0);
    run_burst("post_reset", 16'h0777, BASE + 32'h40C, 8'd0, 3'd2, 2'd1, 0, 0, 0);
    chk("post_reset_count_abs", wr_count_o, 1);
    rd_check("midreset_partial", 32'h304 >> 2);
    rd_check("post_reset_rd", 32'h40C >> 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
